// File: rtl/doorbell_writer.sv
// NVMe SQ0-tail / CQ0-head doorbell writer: turns one-cycle requests into 2-beat RQ memory-write TLPs.
// Optional write counter output db_wr_count is built when DOORBELL_WR_CNT_EN is defined.
module doorbell_writer #(
    parameter int          C_DATA_WIDTH        = 128,
    parameter int          AXI4_RQ_TUSER_WIDTH = 62,
    parameter int          KEEP_WIDTH          = C_DATA_WIDTH/32,
    parameter logic [63:0] BAR0_ADDR           = 64'h0000_0000_F000_0000,
    parameter int          DSTRD               = 0
) (
    input  logic                           user_clk,
    input  logic                           user_reset_n,
    input  logic                           user_lnk_up,
    input  logic                           write_sqtdbl,
    input  logic [63:0]                    sqt_addr,
    input  logic                           write_cqhdbl,
    input  logic [63:0]                    cqh_addr,
    output logic                           write_sqtdbl_done,
    output logic                           write_cqhdbl_done,
    output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
    output logic                           s_axis_rq_tlast,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
    output logic                           s_axis_rq_tvalid,
    input  logic                           s_axis_rq_tready
`ifdef DOORBELL_WR_CNT_EN
    ,
    output logic [31:0]                    db_wr_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_DESC, S_DATA, S_DONE} state_t;

    localparam logic [63:0] SQ_DB_ADDR = BAR0_ADDR + 64'h1000;
    localparam logic [63:0] CQ_DB_ADDR = BAR0_ADDR + 64'h1000 + (64'd4 << DSTRD);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sq_pend;
    logic        r_cq_pend;
    logic [15:0] r_sq_val;
    logic [15:0] r_cq_val;
    logic        r_sel_cq;
    logic [15:0] r_val;
    logic [7:0]  r_tag;
    logic        w_leave_idle;
    logic        w_pick_cq;
    logic        w_desc;
    logic        w_data;
    logic        w_done;
    logic [63:0] w_db_addr;
    logic        w_unused;

    assign w_unused = &{1'b0, sqt_addr[63:16], cqh_addr[63:16]};

    always_comb begin
        w_state_nxt  = r_state;
        w_leave_idle = 1'b0;
        w_pick_cq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sq_pend || r_cq_pend) begin
                    w_state_nxt  = S_DESC;
                    w_leave_idle = 1'b1;
                    w_pick_cq    = !r_sq_pend;
                end
            end
            S_DESC: if (s_axis_rq_tready) w_state_nxt = S_DATA;
            S_DATA: if (s_axis_rq_tready) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!user_lnk_up) begin
            w_state_nxt  = S_IDLE;
            w_leave_idle = 1'b0;
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state  <= S_IDLE;
            r_sel_cq <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_leave_idle) r_sel_cq <= w_pick_cq;
        end
    end

    // A new pulse wins over the clear on the cycle the FSM leaves IDLE, so no request is lost.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_sq_pend <= 1'b0;
            r_cq_pend <= 1'b0;
        end else if (!user_lnk_up) begin
            r_sq_pend <= 1'b0;
            r_cq_pend <= 1'b0;
        end else begin
            if (write_sqtdbl)                   r_sq_pend <= 1'b1;
            else if (w_leave_idle && !w_pick_cq) r_sq_pend <= 1'b0;
            if (write_cqhdbl)                   r_cq_pend <= 1'b1;
            else if (w_leave_idle && w_pick_cq)  r_cq_pend <= 1'b0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_lnk_up && write_sqtdbl) r_sq_val <= sqt_addr[15:0];
        if (user_lnk_up && write_cqhdbl) r_cq_val <= cqh_addr[15:0];
        if (w_leave_idle)                r_val    <= w_pick_cq ? r_cq_val : r_sq_val;
    end

    assign w_desc = (r_state == S_DESC) && user_lnk_up;
    assign w_data = (r_state == S_DATA) && user_lnk_up;
    assign w_done = (r_state == S_DONE) && user_lnk_up;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) r_tag <= 8'd0;
        else if (w_done)   r_tag <= r_tag + 8'd1;
    end

    assign write_sqtdbl_done = w_done && !r_sel_cq;
    assign write_cqhdbl_done = w_done && r_sel_cq;
    assign w_db_addr         = r_sel_cq ? CQ_DB_ADDR : SQ_DB_ADDR;

    // Beats are decoded from registered state only, so they hold steady under backpressure.
    always_comb begin
        s_axis_rq_tdata  = '0;
        s_axis_rq_tkeep  = '0;
        s_axis_rq_tlast  = 1'b0;
        s_axis_rq_tuser  = '0;
        s_axis_rq_tvalid = 1'b0;
        if (w_desc) begin
            s_axis_rq_tvalid        = 1'b1;
            s_axis_rq_tkeep         = '1;
            s_axis_rq_tdata[63:2]   = w_db_addr[63:2];
            s_axis_rq_tdata[74:64]  = 11'd1;
            s_axis_rq_tdata[78:75]  = 4'b0001;
            s_axis_rq_tdata[103:96] = r_tag;
            s_axis_rq_tuser[3:0]    = 4'hF;
        end else if (w_data) begin
            s_axis_rq_tvalid      = 1'b1;
            s_axis_rq_tlast       = 1'b1;
            s_axis_rq_tkeep       = KEEP_WIDTH'(1);
            s_axis_rq_tdata[31:0] = {16'h0, r_val};
            s_axis_rq_tuser[3:0]  = 4'hF;
        end
    end

`ifdef DOORBELL_WR_CNT_EN
    logic [31:0] r_wr_count;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n)                         r_wr_count <= 32'd0;
        else if (w_done && (r_wr_count != '1))     r_wr_count <= r_wr_count + 32'd1;
    end

    assign db_wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_doorbell_writer.sv
// Self-checking bench for doorbell_writer: directed scenarios plus a randomized run against a TLP-level model.
module tb_doorbell_writer;

    localparam logic [63:0] BAR0 = 64'h0000_0000_F000_0000;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic [61:0]  u;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lnk = 1'b0;
    logic         wsq = 1'b0;
    logic         wcq = 1'b0;
    logic [63:0]  sqv = '0;
    logic [63:0]  cqv = '0;
    logic         sq_done;
    logic         cq_done;
    logic [127:0] tdata;
    logic [3:0]   tkeep;
    logic         tlast;
    logic [61:0]  tuser;
    logic         tvalid;
    logic         tready = 1'b0;
`ifdef DOORBELL_WR_CNT_EN
    logic [31:0]  wr_cnt;
`endif

    always #5 clk = ~clk;

    doorbell_writer dut (
        .user_clk          (clk),
        .user_reset_n      (rst_n),
        .user_lnk_up       (lnk),
        .write_sqtdbl      (wsq),
        .sqt_addr          (sqv),
        .write_cqhdbl      (wcq),
        .cqh_addr          (cqv),
        .write_sqtdbl_done (sq_done),
        .write_cqhdbl_done (cq_done),
        .s_axis_rq_tdata   (tdata),
        .s_axis_rq_tkeep   (tkeep),
        .s_axis_rq_tlast   (tlast),
        .s_axis_rq_tuser   (tuser),
        .s_axis_rq_tvalid  (tvalid),
        .s_axis_rq_tready  (tready)
`ifdef DOORBELL_WR_CNT_EN
        ,
        .db_wr_count       (wr_cnt)
`endif
    );

    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     pc = 0;
    int     last_done_cyc = 0;
    int     stall_cnt = 0;
    int     unstable = 0;
    logic   prev_stall = 1'b0;
    beat_t  prev_bus = '0;
    beat_t  beat_q[$];
    int     done_q[$];
    bit     rand_mode = 1'b0;
    logic   ready_val = 1'b1;
    logic [7:0] m_tag = 8'd0;
    int     m_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid && tready) beat_q.push_back({tdata, tkeep, tlast, tuser});
        if (sq_done) begin done_q.push_back(0); last_done_cyc <= cyc; end
        if (cq_done) begin done_q.push_back(1); last_done_cyc <= cyc; end
        if (tvalid && !tready) stall_cnt <= stall_cnt + 1;
        if (prev_stall && tvalid && ({tdata, tkeep, tlast, tuser} !== prev_bus)) unstable <= unstable + 1;
        prev_stall <= tvalid && !tready;
        prev_bus   <= {tdata, tkeep, tlast, tuser};
    end

    initial forever begin
        @(posedge clk);
        #2;
        tready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input bit s, input bit c, input logic [63:0] sv, input logic [63:0] cv);
        @(posedge clk); #1;
        wsq = s; wcq = c; sqv = sv; cqv = cv; pc = cyc;
        @(posedge clk); #1;
        wsq = 1'b0; wcq = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        cycles(2);
        beat_q.delete();
        done_q.delete();
        m_tag = 8'd0;
        m_total = 0;
        rst_n = 1'b1;
        cycles(1);
    endtask

    // Waits for one complete TLP plus its done pulse and checks it against the model's next expectation.
    task automatic check_tlp(input bit is_cq, input logic [15:0] val);
        int           t;
        beat_t        b0;
        beat_t        b1;
        int           dn;
        logic [63:0]  a;
        logic [127:0] exp0;
        t = 0;
        while ((beat_q.size() < 2 || done_q.size() < 1) && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (beat_q.size() < 2 || done_q.size() < 1) begin
            chk("tlp_arrive", 128'(beat_q.size() * 10 + done_q.size()), 128'(21));
            return;
        end
        b0 = beat_q.pop_front();
        b1 = beat_q.pop_front();
        dn = done_q.pop_front();
        a = BAR0 + 64'h1000 + (is_cq ? 64'd4 : 64'd0);
        exp0 = '0;
        exp0[63:2]   = a[63:2];
        exp0[74:64]  = 11'd1;
        exp0[78:75]  = 4'b0001;
        exp0[103:96] = m_tag;
        chk("desc_beat", b0.d, exp0);
        chk("desc_ctrl", 128'({b0.k, b0.l, b0.u}), 128'({4'hF, 1'b0, 62'hF}));
        chk("data_beat", b1.d, {112'h0, val});
        chk("data_ctrl", 128'({b1.k, b1.l, b1.u}), 128'({4'h1, 1'b1, 62'hF}));
        chk("done_queue", 128'(dn), 128'(is_cq));
        m_tag = m_tag + 8'd1;
        m_total++;
    endtask

    initial begin
        int s0;
        int u0;
        bit s;
        bit c;
        logic [63:0] sv;
        logic [63:0] cv;

        lnk = 1'b1;
        cycles(3);
        chk("rst_tvalid", 128'(tvalid), 128'(0));
        chk("rst_tdata", tdata, 128'(0));
        chk("rst_ctrl", 128'({tkeep, tlast, tuser}), 128'(0));
        chk("rst_done", 128'({sq_done, cq_done}), 128'(0));
`ifdef DOORBELL_WR_CNT_EN
        chk("rst_count", 128'(wr_cnt), 128'(0));
`endif
        rst_n = 1'b1;
        cycles(2);

        // single SQ doorbell, latency with tready high
        ready_val = 1'b1;
        pulse(1'b1, 1'b0, 64'd5, 64'd0);
        check_tlp(1'b0, 16'h5);
        chk("sq_latency", 128'(last_done_cyc - pc), 128'(4));

        // simultaneous requests: SQ first, then CQ
        do_reset();
        pulse(1'b1, 1'b1, 64'd3, 64'd7);
        check_tlp(1'b0, 16'h3);
        check_tlp(1'b1, 16'h7);

        // 10-cycle backpressure on the descriptor beat
        do_reset();
        ready_val = 1'b0;
        s0 = stall_cnt;
        u0 = unstable;
        pulse(1'b1, 1'b0, 64'h1234_0000_0000_0009, 64'd0);
        while (cyc < pc + 12) begin @(posedge clk); #1; end
        ready_val = 1'b1;
        check_tlp(1'b0, 16'h0009);
        chk("stall_latency", 128'(last_done_cyc - pc), 128'(14));
        chk("stall_cycles", 128'(stall_cnt - s0), 128'(10));
        chk("stall_stable", 128'(unstable - u0), 128'(0));

        // two SQ pulses while a CQ TLP is in flight collapse into one
        do_reset();
        pulse(1'b0, 1'b1, 64'd0, 64'd77);
        @(posedge clk); #1;
        wsq = 1'b1; sqv = 64'd1;
        @(posedge clk); #1;
        sqv = 64'd2;
        @(posedge clk); #1;
        wsq = 1'b0;
        check_tlp(1'b1, 16'd77);
        check_tlp(1'b0, 16'd2);
        cycles(10);
        chk("coalesce_extra", 128'(beat_q.size() + done_q.size()), 128'(0));

        // requests ignored while link is down
        lnk = 1'b0;
        pulse(1'b1, 1'b1, 64'd11, 64'd12);
        cycles(4);
        lnk = 1'b1;
        cycles(8);
        chk("lnkdn_ignore", 128'(beat_q.size() + done_q.size()), 128'(0));

        // link drop while stalled in the descriptor beat abandons the TLP
        ready_val = 1'b0;
        pulse(1'b1, 1'b0, 64'd13, 64'd0);
        cycles(2);
        chk("lnk_pre_tvalid", 128'(tvalid), 128'(1));
        lnk = 1'b0;
        cycles(1);
        chk("lnk_drop_tvalid", 128'(tvalid), 128'(0));
        cycles(4);
        lnk = 1'b1;
        ready_val = 1'b1;
        cycles(8);
        chk("lnk_drop_quiet", 128'(beat_q.size() + done_q.size()), 128'(0));
        pulse(1'b0, 1'b1, 64'd0, 64'hBEEF);
        check_tlp(1'b1, 16'hBEEF);

        // reset asserted during the data beat
        ready_val = 1'b1;
        pulse(1'b1, 1'b0, 64'd21, 64'd0);
        cycles(2);
        chk("in_data_beat", 128'({tvalid, tlast}), 128'(3));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 128'(tvalid), 128'(0));
        cycles(2);
        beat_q.delete();
        m_tag = 8'd0;
        m_total = 0;
        rst_n = 1'b1;
        cycles(8);
        chk("rst_mid_nodone", 128'(done_q.size() + beat_q.size()), 128'(0));
        pulse(1'b1, 1'b0, 64'd22, 64'd0);
        check_tlp(1'b0, 16'd22);

        // randomized traffic with random backpressure; 300 TLPs wrap the tag
        do_reset();
        rand_mode = 1'b1;
        while (m_total < 300) begin
            s = ($urandom_range(0, 2) != 0);
            c = $urandom_range(0, 1);
            if (!s && !c) s = 1'b1;
            if (m_total == 299) begin s = 1'b1; c = 1'b0; end
            sv = {$urandom(), $urandom()};
            cv = {$urandom(), $urandom()};
            cycles($urandom_range(0, 3));
            pulse(s, c, sv, cv);
            if (s) check_tlp(1'b0, sv[15:0]);
            if (c) check_tlp(1'b1, cv[15:0]);
        end
        rand_mode = 1'b0;
        cycles(3);
`ifdef DOORBELL_WR_CNT_EN
        chk("wr_count", 128'(wr_cnt), 128'(m_total));
`endif
        pulse(1'b1, 1'b0, 64'h0000_0000_0000_ABCD, 64'd0);
        check_tlp(1'b0, 16'hABCD);
        cycles(5);
        chk("final_quiet", 128'(beat_q.size() + done_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
